// File: rtl/data_stream_upsizer_if.sv
// Ready/valid/data/strb stream bundle shared by the narrow and wide sides of the upsizer.
interface data_stream_upsizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;
  logic                  valid;
  logic                  ready;

  modport master (output data, output strb, output valid, input ready);
  modport slave  (input data, input strb, input valid, output ready);
endinterface

// File: rtl/data_stream_upsizer.sv
// Packs RATIO narrow stream beats into one wide beat, first beat in the lowest lane.
// Optional partial-word flush is enabled by defining DATA_STREAM_UPSIZER_FLUSH_EN.
module data_stream_upsizer #(
  parameter int DATA_WIDTH_IN = 32,
  parameter int RATIO         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_stream_upsizer_if.slave  s_if,
  data_stream_upsizer_if.master m_if
`ifdef DATA_STREAM_UPSIZER_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int DATA_WIDTH_OUT = DATA_WIDTH_IN * RATIO;
  localparam int STRB_WIDTH_IN  = DATA_WIDTH_IN / 8;
  localparam int STRB_WIDTH_OUT = STRB_WIDTH_IN * RATIO;
  localparam int CNT_W          = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int ACC_DW         = DATA_WIDTH_IN * (RATIO - 1);
  localparam int ACC_SW         = STRB_WIDTH_IN * (RATIO - 1);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  generate
    if ((DATA_WIDTH_IN % 8) != 0 || DATA_WIDTH_IN < 8) begin : g_bad_width
      $error("data_stream_upsizer: DATA_WIDTH_IN must be a non-zero multiple of 8");
    end
    if (RATIO < 2) begin : g_bad_ratio
      $error("data_stream_upsizer: RATIO must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0]          r_lane_cnt;
  logic [ACC_DW-1:0]         r_acc_data;
  logic [ACC_SW-1:0]         r_acc_strb;
  logic [DATA_WIDTH_OUT-1:0] r_out_data;
  logic [STRB_WIDTH_OUT-1:0] r_out_strb;
  logic                      r_out_valid;

  logic                      w_out_free;
  logic                      w_last;
  logic                      w_s_ready;
  logic                      w_s_hs;
  logic                      w_close;
  logic [DATA_WIDTH_OUT-1:0] w_acc_data_ext;
  logic [STRB_WIDTH_OUT-1:0] w_acc_strb_ext;
  logic [DATA_WIDTH_OUT-1:0] w_word_data;
  logic [STRB_WIDTH_OUT-1:0] w_word_strb;

  assign w_out_free = !r_out_valid | m_if.ready;
  assign w_last     = (r_lane_cnt == LAST_LANE);
  assign w_s_hs     = s_if.valid & w_s_ready;

`ifdef DATA_STREAM_UPSIZER_FLUSH_EN
  logic w_lane_busy;
  logic w_flush_hold;

  assign w_lane_busy  = (r_lane_cnt != '0);
  assign w_flush_hold = flush & w_lane_busy;
  // A pending flush freezes intake until the output register can take the partial word.
  assign w_s_ready    = rst_n & (w_flush_hold ? w_out_free : (!w_last | w_out_free));
  assign w_close      = (w_s_hs & w_last) | (flush & w_out_free & (w_s_hs | w_lane_busy));
`else
  assign w_s_ready    = rst_n & (!w_last | w_out_free);
  assign w_close      = w_s_hs & w_last;
`endif

  assign w_acc_data_ext = {{DATA_WIDTH_IN{1'b0}}, r_acc_data};
  assign w_acc_strb_ext = {{STRB_WIDTH_IN{1'b0}}, r_acc_strb};

  // Lanes below lane_cnt come from the accumulator, the current beat fills lane lane_cnt,
  // and anything above is zero so a partial word carries clean data and strobes.
  always_comb begin
    w_word_data = '0;
    w_word_strb = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) < r_lane_cnt) begin
        w_word_data[k*DATA_WIDTH_IN +: DATA_WIDTH_IN] = w_acc_data_ext[k*DATA_WIDTH_IN +: DATA_WIDTH_IN];
        w_word_strb[k*STRB_WIDTH_IN +: STRB_WIDTH_IN] = w_acc_strb_ext[k*STRB_WIDTH_IN +: STRB_WIDTH_IN];
      end else if (CNT_W'(k) == r_lane_cnt && w_s_hs) begin
        w_word_data[k*DATA_WIDTH_IN +: DATA_WIDTH_IN] = s_if.data;
        w_word_strb[k*STRB_WIDTH_IN +: STRB_WIDTH_IN] = s_if.strb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_cnt <= '0;
      r_acc_data <= '0;
      r_acc_strb <= '0;
    end else if (w_close) begin
      r_lane_cnt <= '0;
      r_acc_strb <= '0;
    end else if (w_s_hs) begin
      r_lane_cnt <= r_lane_cnt + 1'b1;
      for (int k = 0; k < RATIO - 1; k++) begin
        if (CNT_W'(k) == r_lane_cnt) begin
          r_acc_data[k*DATA_WIDTH_IN +: DATA_WIDTH_IN] <= s_if.data;
          r_acc_strb[k*STRB_WIDTH_IN +: STRB_WIDTH_IN] <= s_if.strb;
        end
      end
    end
  end

  // w_close only fires when the output register is free, so a load never overwrites a pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_close) begin
      r_out_data  <= w_word_data;
      r_out_strb  <= w_word_strb;
      r_out_valid <= 1'b1;
    end else if (m_if.ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign s_if.ready = w_s_ready;
  assign m_if.data  = r_out_data;
  assign m_if.strb  = r_out_strb;
  assign m_if.valid = r_out_valid;

endmodule

// File: tb/tb_data_stream_upsizer.sv
// Self-checking bench for data_stream_upsizer: directed steps plus random traffic against a word-level queue model.
module tb_data_stream_upsizer;

  localparam int DW    = 32;
  localparam int RATIO = 4;
`ifdef DATA_STREAM_UPSIZER_FLUSH_EN
  localparam bit FLUSH_SUPPORTED = 1'b1;
`else
  localparam bit FLUSH_SUPPORTED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic flushSig;

  data_stream_upsizer_if #(.DATA_WIDTH(DW), .STRB_WIDTH(DW/8)) sIf ();
  data_stream_upsizer_if #(.DATA_WIDTH(DW*RATIO), .STRB_WIDTH(DW/8*RATIO)) mIf ();

  data_stream_upsizer #(.DATA_WIDTH_IN(DW), .RATIO(RATIO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (sIf),
    .m_if  (mIf)
`ifdef DATA_STREAM_UPSIZER_FLUSH_EN
    ,
    .flush (flushSig)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: beats collected into a partial word, completed words queued for the output.
  logic [31:0]  partData [RATIO];
  logic [3:0]   partStrb [RATIO];
  int           partCnt = 0;
  logic [127:0] qData [$];
  logic [15:0]  qStrb [$];

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    partCnt = 0;
    qData.delete();
    qStrb.delete();
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    sIf.valid = 1'b0;
    sIf.data  = '0;
    sIf.strb  = '0;
    mIf.ready = 1'b0;
    flushSig  = 1'b0;
    #1;
    checkOutput("rst_s_ready", 128'(sIf.ready), 128'(0));
    checkOutput("rst_m_valid", 128'(mIf.valid), 128'(0));
    checkOutput("rst_m_data",  mIf.data, 128'(0));
    checkOutput("rst_m_strb",  128'(mIf.strb), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  // One clock cycle: drive at the falling edge, check pre-edge outputs, advance the model at the rising edge.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [3:0] st,
                               input bit mr, input bit fl, output bit acc);
    bit flEff, outFree, expReady, sRdy, mVal;
    logic [127:0] wd;
    logic [15:0]  ws;
    sIf.valid = v;
    sIf.data  = d;
    sIf.strb  = st;
    mIf.ready = mr;
    flushSig  = fl;
    #1;
    flEff    = fl & FLUSH_SUPPORTED;
    outFree  = (qData.size() == 0) || mr;
    expReady = (flEff && partCnt > 0) ? outFree : ((partCnt != RATIO - 1) || outFree);
    sRdy     = sIf.ready;
    mVal     = mIf.valid;
    checkOutput("s_ready", 128'(sRdy), 128'(expReady));
    checkOutput("m_valid", 128'(mVal), 128'(qData.size() != 0));
    if (qData.size() != 0) begin
      checkOutput("m_data", mIf.data, qData[0]);
      checkOutput("m_strb", 128'(mIf.strb), 128'(qStrb[0]));
    end
    @(posedge clk);
    acc = v && sRdy;
    if (mVal && mr && qData.size() != 0) begin
      void'(qData.pop_front());
      void'(qStrb.pop_front());
    end
    if (acc && partCnt < RATIO) begin
      partData[partCnt] = d;
      partStrb[partCnt] = st;
      partCnt++;
    end
    if (partCnt == RATIO || (flEff && outFree && partCnt > 0)) begin
      wd = '0;
      ws = '0;
      for (int k = 0; k < partCnt; k++) begin
        wd[k*32 +: 32] = partData[k];
        ws[k*4 +: 4]   = partStrb[k];
      end
      qData.push_back(wd);
      qStrb.push_back(ws);
      partCnt = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int cnt;
    int beatIdx;
    rst_n     = 1'b0;
    flushSig  = 1'b0;
    sIf.valid = 1'b0;
    sIf.data  = '0;
    sIf.strb  = '0;
    mIf.ready = 1'b0;
    @(negedge clk);
    doReset();

    // Single word of four known beats.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'h11111111 * i, 4'hF, 1'b1, 1'b0, acc);
    #1;
    checkOutput("word1_valid", 128'(mIf.valid), 128'(1));
    checkOutput("word1_data",  mIf.data, 128'h44444444_33333333_22222222_11111111);
    checkOutput("word1_strb",  128'(mIf.strb), 128'hFFFF);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);

    // Sixteen back-to-back beats with the consumer always ready.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'hA0000000 + i, 4'hF, 1'b1, 1'b0, acc);
      if (acc) cnt++;
    end
    checkOutput("stream16_accepted", 128'(cnt), 128'(16));
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);

    // Backpressure: consumer stalled for eight cycles, then released.
    beatIdx = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 32'hB0000000 + beatIdx, 4'hF, 1'b0, 1'b0, acc);
      if (acc) beatIdx++;
    end
    checkOutput("bp_accepted", 128'(beatIdx), 128'(7));
    for (int c = 0; c < 20 && beatIdx < 8; c++) begin
      applyStimulus(1'b1, 32'hB0000000 + beatIdx, 4'hF, 1'b1, 1'b0, acc);
      if (acc) beatIdx++;
    end
    checkOutput("bp_all_accepted", 128'(beatIdx), 128'(8));
    repeat (3) applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);

    // Partial strobe in lane 1, data untouched.
    applyStimulus(1'b1, 32'hC0C0C0C0, 4'hF, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'hC1C1C1C1, 4'h3, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'hC2C2C2C2, 4'hF, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'hC3C3C3C3, 4'hF, 1'b1, 1'b0, acc);
    #1;
    checkOutput("strb_lane1", 128'(mIf.strb), 128'hFF3F);
    checkOutput("strb_data",  mIf.data, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);

    // Mid-word reset discards the partial word.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hDEAD0000 + i, 4'hF, 1'b1, 1'b0, acc);
    doReset();
    repeat (2) applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);
    for (int i = 5; i <= 8; i++) applyStimulus(1'b1, 32'h11111111 * i, 4'hF, 1'b0, 1'b0, acc);
    #1;
    checkOutput("post_rst_data", mIf.data, 128'h88888888_77777777_66666666_55555555);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);

`ifdef DATA_STREAM_UPSIZER_FLUSH_EN
    // Flush of a two-beat partial word, then flush together with a third beat.
    applyStimulus(1'b1, 32'h0000000A, 4'hF, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'h0000000B, 4'hF, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, acc);
    #1;
    checkOutput("flush2_data", mIf.data, 128'h00000000_00000000_0000000B_0000000A);
    checkOutput("flush2_strb", 128'(mIf.strb), 128'h00FF);
    applyStimulus(1'b1, 32'h0000000C, 4'hF, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'h0000000D, 4'hF, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'h0000000E, 4'hF, 1'b1, 1'b1, acc);
    #1;
    checkOutput("flush3_strb", 128'(mIf.strb), 128'h0FFF);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);
`endif

    // Randomized traffic with random backpressure and occasional flush requests.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, acc);
    end
    repeat (4) applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
